mem_arb2: RTL and testbench
===========================

MEM_ARB2 -- requirements
Module: mem_arb2

Interface
REQ-001 The block SHALL have parameter MEM_AW, default 16, memory address width.
REQ-002 The block SHALL have parameter MEM_DW, default 32, memory data width.
REQ-003 The block SHALL have parameter MAX_OUTS, default 4, maximum outstanding reads (power of 2, >=2).
REQ-004 The block SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 The block SHALL have port ena  input  1  grant enable; 0 freezes new grants.
REQ-007 The block SHALL have ports rN_req  input  1  requester N access request (N=0,1).
REQ-008 The block SHALL have ports rN_write  input  1  1=write, 0=read.
REQ-009 The block SHALL have ports rN_addr  input  MEM_AW  requester N address.
REQ-010 The block SHALL have ports rN_wdata  input  MEM_DW  requester N write data.
REQ-011 The block SHALL have ports rN_gnt  output  1  request accepted this cycle (combinational).
REQ-012 The block SHALL have ports rN_rdata_vld  output  1  read data valid for requester N.
REQ-013 The block SHALL have ports rN_rdata  output  MEM_DW  read data to requester N.
REQ-014 The block SHALL have ports mem_req, mem_write  output  1  memory request / write strobe.
REQ-015 The block SHALL have ports mem_addr  output  MEM_AW, and mem_wdata  output  MEM_DW.
REQ-016 The block SHALL have ports mem_rdata_vld  input  1, and mem_rdata  input  MEM_DW  memory read return, in request order, latency >=1.
REQ-017 The block SHALL have port err_unexp  output  1  sticky: read return seen with no outstanding read.

Function
REQ-018 Requester SHALL hold rN_req/write/addr/wdata stable until rN_gnt; request transfers in cycle where rN_req & rN_gnt.
REQ-019 A requester is eligible when rN_req=1 and (rN_write=1 or tag FIFO not full, counting a same-cycle pop).
REQ-020 At most one gnt SHALL be asserted per cycle; none when ena=0.
REQ-021 Arbitration SHALL be round-robin: pointer last=ID of last granted; with both eligible, grant !last; with one eligible, grant it; last updates only on grant.
REQ-022 Granted request SHALL appear on mem_* registered, exactly 1 cycle after gnt; mem_req=0 in cycles with no prior-cycle grant.
REQ-023 Each granted read SHALL push its requester ID into an in-order tag FIFO of depth MAX_OUTS; writes push nothing.
REQ-024 On mem_rdata_vld=1 with FIFO non-empty, head ID SHALL be popped and rID_rdata_vld=1 same cycle (combinational route), rdata = mem_rdata; other requester's vld=0.
REQ-025 Simultaneous push and pop SHALL both take effect; occupancy unchanged; full with same-cycle pop permits a read grant.
REQ-026 mem_rdata_vld=1 with FIFO empty SHALL be dropped (no rN_rdata_vld) and set err_unexp until reset.
REQ-027 rN_rdata SHALL equal mem_rdata at all times (only vld is routed).
REQ-028 Throughput SHALL be one granted request per cycle sustained when eligible.

Reset
REQ-029 On rst_n=0: mem_req=0, mem_write=0, mem_addr=0, mem_wdata=0, last=1 (r0 wins first tie), FIFO empty, err_unexp=0; gnt/rdata_vld forced 0 while in reset.
REQ-030 Reset mid-operation SHALL discard outstanding tags; returns arriving after reset release SHALL set err_unexp.

Structure
REQ-031 Package mem_arb_pkg SHALL hold default MEM_AW/MEM_DW/MAX_OUTS constants and requester-ID typedef (1 bit).
REQ-032 Tag FIFO SHALL be sub-module rd_tag_fifo (push, pop, id_in, id_out, full, empty; pointer+count).

Verification
REQ-033 r0 only, 4 reads addr 0x100..0x103, memory latency 2 -> 4 mem_req cycles back-to-back, r0_rdata_vld x4 in order, r1_rdata_vld never.
REQ-034 r0 and r1 both hold reads continuously -> grants alternate r0,r1,r0,r1 starting r0 after reset; returns routed matching order.
REQ-035 MAX_OUTS=4, r1 issues 6 reads, memory withholds returns -> only 4 grants; 5th granted in cycle of first return.
REQ-036 r0 write 0x300 data 0x1234 with r1 read pending, ena=0 for 20 cycles -> no gnt during ena=0; after ena=1 write then read granted, mem_write=1 only on write cycle.
REQ-037 Two reads outstanding, pulse rst_n low 30 cycles, memory then returns 2 words -> no rN_rdata_vld, err_unexp=1.
REQ-038 Write-only traffic from both at full rate with FIFO full -> writes still granted every cycle.

Source files
------------

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// mem_arb_pkg : shared defaults and requester-ID type for the two-port arbiter
// Rev 1.0
// ============================================================================
package mem_arb_pkg;

    localparam int C_MEM_AW_DEF   = 16;
    localparam int C_MEM_DW_DEF   = 32;
    localparam int C_MAX_OUTS_DEF = 4;

    typedef logic req_id_t;

    localparam req_id_t C_ID_R0 = 1'b0;
    localparam req_id_t C_ID_R1 = 1'b1;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/rd_tag_fifo.sv
`default_nettype none
// ============================================================================
// rd_tag_fifo : in-order FIFO of requester IDs for outstanding reads
// Rev 1.0
// ============================================================================
module rd_tag_fifo
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = C_MAX_OUTS_DEF
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push,
    input  logic    pop,
    input  req_id_t id_in,
    output req_id_t id_out,
    output logic    full,
    output logic    empty
);

    localparam int C_PW = $clog2(DEPTH);

    req_id_t         slot_q [DEPTH];
    logic [C_PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [C_PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [C_PW:0]   count_q,  count_d;
    logic            w_do_push;
    logic            w_do_pop;

    assign empty     = (count_q == '0);
    assign full      = (count_q == (C_PW+1)'(DEPTH));
    assign id_out    = slot_q[rd_ptr_q];
    assign w_do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot the push is about to use.
    assign w_do_push = push & (~full | w_do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (w_do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({w_do_push, w_do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) slot_q[wr_ptr_q] <= id_in;
    end

endmodule : rd_tag_fifo
`default_nettype wire

// File: rtl/mem_arb2.sv
`default_nettype none
// ============================================================================
// mem_arb2 : round-robin arbiter of two requesters onto one pipelined memory
// Rev 1.0
// ============================================================================
module mem_arb2
    import mem_arb_pkg::*;
#(
    parameter int MEM_AW   = C_MEM_AW_DEF,
    parameter int MEM_DW   = C_MEM_DW_DEF,
    parameter int MAX_OUTS = C_MAX_OUTS_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              r0_req,
    input  logic              r0_write,
    input  logic [MEM_AW-1:0] r0_addr,
    input  logic [MEM_DW-1:0] r0_wdata,
    output logic              r0_gnt,
    output logic              r0_rdata_vld,
    output logic [MEM_DW-1:0] r0_rdata,
    input  logic              r1_req,
    input  logic              r1_write,
    input  logic [MEM_AW-1:0] r1_addr,
    input  logic [MEM_DW-1:0] r1_wdata,
    output logic              r1_gnt,
    output logic              r1_rdata_vld,
    output logic [MEM_DW-1:0] r1_rdata,
    output logic              mem_req,
    output logic              mem_write,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [MEM_DW-1:0] mem_wdata,
    input  logic              mem_rdata_vld,
    input  logic [MEM_DW-1:0] mem_rdata,
    output logic              err_unexp
);

    logic              w_fifo_full, w_fifo_empty;
    logic              w_push, w_pop, w_rd_ok;
    logic              w_elig0, w_elig1, w_gnt0, w_gnt1;
    req_id_t           w_head_id, w_push_id;

    req_id_t           last_q, last_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_write_q, mem_write_d;
    logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
    logic [MEM_DW-1:0] mem_wdata_q, mem_wdata_d;
    logic              err_q, err_d;

    assign w_pop   = mem_rdata_vld & ~w_fifo_empty;
    // A full FIFO still accepts a read when the head is leaving this cycle.
    assign w_rd_ok = ~w_fifo_full | w_pop;
    assign w_elig0 = r0_req & (r0_write | w_rd_ok);
    assign w_elig1 = r1_req & (r1_write | w_rd_ok);

    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (rst_n && ena) begin
            if (w_elig0 && w_elig1) begin
                w_gnt0 = (last_q == C_ID_R1);
                w_gnt1 = (last_q == C_ID_R0);
            end else begin
                w_gnt0 = w_elig0;
                w_gnt1 = w_elig1;
            end
        end
    end

    assign w_push    = (w_gnt0 & ~r0_write) | (w_gnt1 & ~r1_write);
    assign w_push_id = w_gnt1 ? C_ID_R1 : C_ID_R0;

    rd_tag_fifo #(
        .DEPTH (MAX_OUTS)
    ) u_tag_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (w_push),
        .pop    (w_pop),
        .id_in  (w_push_id),
        .id_out (w_head_id),
        .full   (w_fifo_full),
        .empty  (w_fifo_empty)
    );

    always_comb begin
        last_d      = last_q;
        mem_req_d   = w_gnt0 | w_gnt1;
        mem_write_d = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (w_gnt0) begin
            last_d      = C_ID_R0;
            mem_write_d = r0_write;
            mem_addr_d  = r0_addr;
            mem_wdata_d = r0_wdata;
        end else if (w_gnt1) begin
            last_d      = C_ID_R1;
            mem_write_d = r1_write;
            mem_addr_d  = r1_addr;
            mem_wdata_d = r1_wdata;
        end
        err_d = err_q | (mem_rdata_vld & w_fifo_empty);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q      <= C_ID_R1;
            mem_req_q   <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            err_q       <= 1'b0;
        end else begin
            last_q      <= last_d;
            mem_req_q   <= mem_req_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            err_q       <= err_d;
        end
    end

    assign r0_gnt       = w_gnt0;
    assign r1_gnt       = w_gnt1;
    assign r0_rdata_vld = rst_n & w_pop & (w_head_id == C_ID_R0);
    assign r1_rdata_vld = rst_n & w_pop & (w_head_id == C_ID_R1);
    assign r0_rdata     = mem_rdata;
    assign r1_rdata     = mem_rdata;
    assign mem_req      = mem_req_q;
    assign mem_write    = mem_write_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign err_unexp    = err_q;

endmodule : mem_arb2
`default_nettype wire

// File: tb/tb_mem_arb2.sv
`default_nettype none
// ============================================================================
// tb_mem_arb2 : randomized traffic against a queue-based reference model
// Rev 1.0
// ============================================================================
module tb_mem_arb2;
    import mem_arb_pkg::*;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int MO = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ena;
    logic          req [2];
    logic          wr  [2];
    logic [AW-1:0] addr[2];
    logic [DW-1:0] wd  [2];
    logic          mem_rdata_vld;
    logic [DW-1:0] mem_rdata;
    logic          r0_gnt, r1_gnt, r0_rdata_vld, r1_rdata_vld;
    logic [DW-1:0] r0_rdata, r1_rdata;
    logic          mem_req, mem_write, err_unexp;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;

    always #5 clk = ~clk;

    mem_arb2 #(.MEM_AW(AW), .MEM_DW(DW), .MAX_OUTS(MO)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .r0_req(req[0]), .r0_write(wr[0]), .r0_addr(addr[0]), .r0_wdata(wd[0]),
        .r0_gnt(r0_gnt), .r0_rdata_vld(r0_rdata_vld), .r0_rdata(r0_rdata),
        .r1_req(req[1]), .r1_write(wr[1]), .r1_addr(addr[1]), .r1_wdata(wd[1]),
        .r1_gnt(r1_gnt), .r1_rdata_vld(r1_rdata_vld), .r1_rdata(r1_rdata),
        .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata_vld(mem_rdata_vld),
        .mem_rdata(mem_rdata), .err_unexp(err_unexp)
    );

    typedef struct {
        logic [DW-1:0] d;
        int            due;
    } ret_t;

    // Reference state: outstanding-read owners, pointer, sticky error, expected mem_* bus.
    int            tagq[$];
    ret_t          memq[$];
    bit            m_last;
    bit            m_err;
    bit            e_req, e_wr;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    bit            granted[2];

    int cyc, n_chk, n_pass;
    int p_req, p_wr, max_lat, p_ena;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, obs, exp);
    endtask

    task automatic step(input bit rst_val);
        int w;
        bit pop_now, can_rd;
        bit el[2];
        @(posedge clk);
        #1;
        rst_n = rst_val;
        #1;
        cyc++;
        if (!rst_n) begin
            check("rst_mem_req",   mem_req,   0);
            check("rst_mem_write", mem_write, 0);
            check("rst_mem_addr",  mem_addr,  0);
            check("rst_mem_wdata", mem_wdata, 0);
            check("rst_err",       err_unexp, 0);
        end else begin
            check("mem_req",   mem_req,   e_req);
            check("mem_write", mem_write, e_wr);
            if (e_req) check("mem_addr", mem_addr, e_addr);
            if (e_req && e_wr) check("mem_wdata", mem_wdata, e_wd);
            check("err_unexp", err_unexp, m_err);
        end
        // Memory side: accept reads, return them in order after random latency.
        if (rst_n && mem_req && !mem_write)
            memq.push_back('{d: $urandom, due: cyc + int'($urandom_range(1, max_lat))});
        for (int i = 0; i < 2; i++) begin
            if (granted[i]) req[i] = 1'b0;
            granted[i] = 1'b0;
            if (!req[i] && $urandom_range(0, 99) < p_req) begin
                req[i]  = 1'b1;
                wr[i]   = ($urandom_range(0, 99) < p_wr);
                addr[i] = AW'($urandom);
                wd[i]   = $urandom;
            end
        end
        ena           = ($urandom_range(0, 99) < p_ena);
        mem_rdata     = $urandom;
        mem_rdata_vld = 1'b0;
        if (rst_n && memq.size() > 0 && memq[0].due <= cyc) begin
            mem_rdata_vld = 1'b1;
            mem_rdata     = memq[0].d;
            void'(memq.pop_front());
        end
        #2;
        pop_now = rst_n && mem_rdata_vld && tagq.size() > 0;
        can_rd  = (tagq.size() < MO) || pop_now;
        for (int i = 0; i < 2; i++) el[i] = req[i] && (wr[i] || can_rd);
        w = -1;
        if (rst_n && ena) begin
            if (el[0] && el[1]) w = m_last ? 0 : 1;
            else if (el[0])     w = 0;
            else if (el[1])     w = 1;
        end
        check("r0_gnt", r0_gnt, w == 0);
        check("r1_gnt", r1_gnt, w == 1);
        check("r0_rdata_vld", r0_rdata_vld, pop_now && tagq[0] == 0);
        check("r1_rdata_vld", r1_rdata_vld, pop_now && tagq[0] == 1);
        check("r0_rdata", r0_rdata, mem_rdata);
        check("r1_rdata", r1_rdata, mem_rdata);
        if (!rst_n) begin
            tagq.delete();
            m_last = 1'b1;
            m_err  = 1'b0;
            e_req  = 1'b0;
            e_wr   = 1'b0;
        end else begin
            if (mem_rdata_vld && tagq.size() == 0) m_err = 1'b1;
            if (pop_now) void'(tagq.pop_front());
            e_req = (w >= 0);
            e_wr  = 1'b0;
            if (w >= 0) begin
                e_wr   = wr[w];
                e_addr = addr[w];
                e_wd   = wd[w];
                if (!wr[w]) tagq.push_back(w);
                m_last     = (w == 1);
                granted[w] = 1'b1;
            end
        end
    endtask

    task automatic run(input int n, input int preq, input int pwr, input int lat, input int pena);
        p_req   = preq;
        p_wr    = pwr;
        max_lat = lat;
        p_ena   = pena;
        repeat (n) step(1'b1);
    endtask

    initial begin
        rst_n         = 1'b0;
        ena           = 1'b0;
        mem_rdata_vld = 1'b0;
        mem_rdata     = '0;
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0; wd[i] = '0; granted[i] = 1'b0;
        end
        m_last = 1'b1; m_err = 1'b0; e_req = 1'b0; e_wr = 1'b0;
        e_addr = '0; e_wd = '0;
        cyc = 0; n_chk = 0; n_pass = 0;
        p_req = 0; p_wr = 0; max_lat = 2; p_ena = 0;

        repeat (3) step(1'b0);
        run(800, 60, 30, 6, 90);
        run(300, 100, 0, 30, 100);
        run(300, 100, 100, 30, 100);
        run(200, 100, 0, 20, 100);
        p_ena = 0;
        repeat (30) step(1'b0);
        // No grants after release, so every stale return is unexpected.
        run(40, 0, 0, 2, 0);
        check("err_after_reset", err_unexp, 1);
        run(800, 70, 40, 8, 85);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_mem_arb2
`default_nettype wire
